axis_reg_slice: RTL and testbench

AXIS_REG_SLICE -- requirements
Module: axis_reg_slice

---
 rtl/axis_reg_slice.sv | 62 ++++++
 tb/tb_axis_reg_slice.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/axis_reg_slice.sv
// axis_reg_slice: two-entry AXI-Stream register slice (output register plus skid register, all outputs registered)
module axis_reg_slice #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  s_axis_tvalid,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    output logic                  s_axis_tready,
    output logic                  m_axis_tvalid,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    input  logic                  m_axis_tready
);
    logic                  rdy_q, rdy_d;
    logic                  m_valid_q, m_valid_d;
    logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic                  skid_valid_q, skid_valid_d;
    logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
    logic                  acc, ld_out;
    assign acc           = s_axis_tvalid & rdy_q;
    assign ld_out        = ~m_valid_q | m_axis_tready;
    assign s_axis_tready = rdy_q;
    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tdata  = m_data_q;
    // Output register refills from skid first, else from input; a stalled output diverts the input into skid
    always_comb begin
        m_valid_d    = m_valid_q;
        m_data_d     = m_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (ld_out) begin
            if (skid_valid_q) begin
                m_valid_d    = 1'b1;
                m_data_d     = skid_data_q;
                skid_valid_d = 1'b0;
            end else begin
                m_valid_d = acc;
                m_data_d  = acc ? s_axis_tdata : m_data_q;
            end
        end else if (acc) begin
            skid_valid_d = 1'b1;
            skid_data_d  = s_axis_tdata;
        end
        rdy_d = ~skid_valid_d;
    end
    // State registers; reset clears both entries and holds tready low until the first edge after release
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdy_q        <= 1'b0;
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            rdy_q        <= rdy_d;
            m_valid_q    <= m_valid_d;
            m_data_q     <= m_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end
endmodule

// File: tb/tb_axis_reg_slice.sv
// tb_axis_reg_slice: table vectors, directed corner sequences and randomized run against a queue model
module tb_axis_reg_slice;
    localparam int W = 32;
    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         s_axis_tvalid = 1'b0;
    logic [W-1:0] s_axis_tdata = '0;
    logic         s_axis_tready;
    logic         m_axis_tvalid;
    logic [W-1:0] m_axis_tdata;
    logic         m_axis_tready = 1'b0;
    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] q[$];
    logic         rdy_m = 1'b0;
    logic [W-1:0] hold_m = '0;
    typedef struct {
        logic         sv;
        logic [W-1:0] d;
        logic         mr;
        logic         er;
        logic         ev;
        logic [W-1:0] ed;
    } vec_t;
    vec_t tbl[13];

    axis_reg_slice #(.DATA_WIDTH(W)) dut (
        .clk(clk),
        .reset(reset),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tdata(s_axis_tdata),
        .s_axis_tready(s_axis_tready),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tdata(m_axis_tdata),
        .m_axis_tready(m_axis_tready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        rdy_m  = 1'b0;
        hold_m = '0;
    endtask

    task automatic step(input logic sv, input logic [W-1:0] d, input logic mr);
        logic acc, pop;
        s_axis_tvalid = sv;
        s_axis_tdata  = d;
        m_axis_tready = mr;
        acc = sv && rdy_m;
        pop = (q.size() > 0) && mr;
        @(posedge clk);
        #1;
        if (pop) void'(q.pop_front());
        if (acc) q.push_back(d);
        if (q.size() > 0) hold_m = q[0];
        rdy_m = q.size() < 2;
    endtask

    task automatic model_check(input string tag);
        chk({tag, " s_ready"}, W'(s_axis_tready), W'(rdy_m));
        chk({tag, " m_valid"}, W'(m_axis_tvalid), W'(q.size() > 0));
        chk({tag, " m_data"}, m_axis_tdata, hold_m);
    endtask

    initial begin
        logic [W-1:0] got[$];
        int i, cyc;
        logic pre;
        tbl[0]  = '{1'b1, 32'hA, 1'b0, 1'b1, 1'b1, 32'hA};
        tbl[1]  = '{1'b1, 32'hB, 1'b0, 1'b0, 1'b1, 32'hA};
        tbl[2]  = '{1'b1, 32'hC, 1'b0, 1'b0, 1'b1, 32'hA};
        tbl[3]  = '{1'b1, 32'hC, 1'b1, 1'b1, 1'b1, 32'hB};
        tbl[4]  = '{1'b1, 32'hC, 1'b1, 1'b1, 1'b1, 32'hC};
        tbl[5]  = '{1'b0, 32'h5, 1'b1, 1'b1, 1'b0, 32'hC};
        tbl[6]  = '{1'b0, 32'h9, 1'b0, 1'b1, 1'b0, 32'hC};
        tbl[7]  = '{1'b1, 32'hD, 1'b1, 1'b1, 1'b1, 32'hD};
        tbl[8]  = '{1'b1, 32'hE, 1'b1, 1'b1, 1'b1, 32'hE};
        tbl[9]  = '{1'b1, 32'hF, 1'b0, 1'b0, 1'b1, 32'hE};
        tbl[10] = '{1'b0, 32'h7, 1'b0, 1'b0, 1'b1, 32'hE};
        tbl[11] = '{1'b0, 32'h7, 1'b1, 1'b1, 1'b1, 32'hF};
        tbl[12] = '{1'b0, 32'h7, 1'b1, 1'b1, 1'b0, 32'hF};

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        model_check("reset");
        reset = 1'b1;
        step(1'b0, '0, 1'b0);
        chk("first edge s_ready", W'(s_axis_tready), W'(1));
        model_check("post reset");

        for (int k = 0; k < 13; k++) begin
            step(tbl[k].sv, tbl[k].d, tbl[k].mr);
            chk($sformatf("vec%0d s_ready", k), W'(s_axis_tready), W'(tbl[k].er));
            chk($sformatf("vec%0d m_valid", k), W'(m_axis_tvalid), W'(tbl[k].ev));
            chk($sformatf("vec%0d m_data", k), m_axis_tdata, tbl[k].ed);
        end

        for (int k = 0; k < 16; k++) begin
            step(1'b1, W'(k), 1'b1);
            chk($sformatf("stream%0d m_data", k), m_axis_tdata, W'(k));
            chk($sformatf("stream%0d m_valid", k), W'(m_axis_tvalid), W'(1));
            chk($sformatf("stream%0d s_ready", k), W'(s_axis_tready), W'(1));
        end
        step(1'b0, '0, 1'b1);
        model_check("stream drain");

        i = 0;
        cyc = 0;
        while ((i < 16 || got.size() < 16) && cyc < 200) begin
            if (m_axis_tvalid && cyc >= 2) got.push_back(m_axis_tdata);
            pre = s_axis_tready;
            step(i < 16, W'(i), cyc >= 2);
            if (i < 16 && pre) i++;
            cyc++;
            model_check("late");
        end
        chk("late count", W'(got.size()), W'(16));
        for (int k = 0; k < 16; k++)
            chk($sformatf("late beat%0d", k), k < got.size() ? got[k] : '1, W'(k));

        step(1'b1, 32'h11, 1'b0);
        step(1'b1, 32'h22, 1'b0);
        model_check("full");
        reset = 1'b0;
        #1;
        model_reset();
        chk("async rst m_valid", W'(m_axis_tvalid), W'(0));
        chk("async rst s_ready", W'(s_axis_tready), W'(0));
        chk("async rst m_data", m_axis_tdata, '0);
        @(posedge clk);
        #1;
        model_check("in reset");
        reset = 1'b1;
        step(1'b0, '0, 1'b1);
        chk("rst release s_ready", W'(s_axis_tready), W'(1));
        chk("rst release m_valid", W'(m_axis_tvalid), W'(0));
        step(1'b0, '0, 1'b1);
        model_check("no stale");

        for (int k = 0; k < 10000; k++) begin
            step(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)));
            model_check("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
